// File: rtl/alu_arb_pkg.sv
// ----------------------------------------------------------------------------
// alu_arb_pkg : opcodes, FSM states and flag helpers for alu_arbiter
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_arb_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADDU = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUBU = 4'b0110;
  localparam logic [3:0] OP_NAND = 4'b0111;
  localparam logic [3:0] OP_ADDS = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SHL  = 4'b1101;
  localparam logic [3:0] OP_SUBS = 4'b1110;
  localparam logic [3:0] OP_SLT  = 4'b1111;

  localparam int FLG_C = 3;
  localparam int FLG_V = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // The ALU leaves don't-care flags undriven; force them to 0 per opcode class.
  function automatic logic [3:0] clean_flags(input logic [3:0] op, input logic c,
                                             input logic v, input logic n,
                                             input logic z);
    logic [3:0] f;
    f        = 4'b0000;
    f[FLG_C] = c;
    f[FLG_V] = v;
    f[FLG_N] = n;
    f[FLG_Z] = z;
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR: begin
        f[FLG_C] = 1'b0;
        f[FLG_V] = 1'b0;
      end
      OP_SHL: begin
        f[FLG_V] = 1'b0;
      end
      OP_SLTU, OP_SLT: begin
        f[FLG_C] = 1'b0;
        f[FLG_V] = 1'b0;
        f[FLG_N] = 1'b0;
      end
      default: ;
    endcase
    return f;
  endfunction

  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op == 4'b0100) || (op == 4'b1000) || (op == 4'b1001) || (op == 4'b1011);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2  : combinational two-way round-robin grant
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter : two-requester round-robin sequencer for the shared ALU.
//               Optional opcode checking via ALU_ARB_OPCHECK_EN.
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [7:0]         req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [3:0]         rsp_flags,
  output logic               rsp_err,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_c,
  input  logic               alu_v,
  input  logic               alu_n,
  input  logic               alu_z
);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic             err_q, err_d;
  logic             rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;

  logic [1:0]       w_grant;
  logic             w_sel;
  logic [3:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_illegal;

  rr_arb2 u_rr_arb2 (
    .req_valid (req_valid),
    .last      (last_q),
    .grant     (w_grant)
  );

  assign w_sel = w_grant[1];
  assign w_op  = w_sel ? req_op[7:4]          : req_op[3:0];
  assign w_a   = w_sel ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign w_b   = w_sel ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

`ifdef ALU_ARB_OPCHECK_EN
  assign w_illegal = op_is_illegal(w_op);
`else
  assign w_illegal = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    err_d       = err_q;
    rsp_err_d   = rsp_err_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;

    case (state_q)
      ST_IDLE: begin
        // Grant is combinational, but must not leak out while reset is held.
        req_ready = rst_n ? w_grant : 2'b00;
        if (w_grant != 2'b00) begin
          state_d = ST_EXEC;
          gnt_d   = w_sel;
          err_d   = w_illegal;
          if (!w_illegal) begin
            alu_a_d    = w_a;
            alu_b_d    = w_b;
            alu_ctrl_d = w_op;
          end
        end
      end
      ST_EXEC: begin
        state_d   = ST_RESP;
        rsp_err_d = err_q;
        if (err_q) begin
          rsp_data_d  = '0;
          rsp_flags_d = 4'b0000;
        end else begin
          rsp_data_d  = alu_out;
          rsp_flags_d = clean_flags(alu_ctrl_q, alu_c, alu_v, alu_n, alu_z);
        end
      end
      ST_RESP: begin
        rsp_valid = gnt_q ? 2'b10 : 2'b01;
        if (rsp_ready[gnt_q]) begin
          state_d = ST_IDLE;
          last_d  = gnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      err_q       <= 1'b0;
      rsp_err_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= 4'b0000;
      rsp_data_q  <= '0;
      rsp_flags_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      err_q       <= err_d;
      rsp_err_q   <= rsp_err_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter : directed self-checking bench for alu_arbiter
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        req_valid = 2'b00;
  logic [1:0]        req_ready;
  logic [7:0]        req_op = 8'h00;
  logic [63:0]       req_a = 64'h0;
  logic [63:0]       req_b = 64'h0;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready = 2'b00;
  logic [WIDTH-1:0]  rsp_data;
  logic [3:0]        rsp_flags;
  logic              rsp_err;
  logic [WIDTH-1:0]  alu_a, alu_b, alu_out;
  logic [3:0]        alu_ctrl;
  logic              alu_c, alu_v, alu_n, alu_z;
  logic              tb_c = 1'b0, tb_v = 1'b0, tb_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z)
  );

  // Stand-in ALU: result from opcode, C/V/N directed by each test, Z from result.
  always_comb begin
    alu_out = alu_a;
    case (alu_ctrl)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0010: alu_out = alu_a + alu_b;
      4'b0011: alu_out = alu_a ^ alu_b;
      4'b0101: alu_out = {31'b0, alu_a < alu_b};
      4'b0110: alu_out = alu_a - alu_b;
      4'b0111: alu_out = ~(alu_a & alu_b);
      4'b1010: alu_out = alu_a + alu_b;
      4'b1100: alu_out = ~(alu_a | alu_b);
      4'b1101: alu_out = alu_a << alu_b[4:0];
      4'b1110: alu_out = alu_a - alu_b;
      4'b1111: alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_out = alu_a;
    endcase
    alu_z = (alu_out == '0);
    alu_c = tb_c;
    alu_v = tb_v;
    alu_n = tb_n;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    if (r == 0) begin
      req_op[3:0] = op; req_a[31:0] = a; req_b[31:0] = b;
    end else begin
      req_op[7:4] = op; req_a[63:32] = a; req_b[63:32] = b;
    end
  endtask

  task automatic test_reset;
    req_valid = 2'b11;
    set_req(0, 4'b0010, 32'h11, 32'h22);
    set_req(1, 4'b0011, 32'h33, 32'h44);
    step;
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready);
    end
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_flags, rsp_err} !== 39'h0) begin
      n_fail++; $display("FAIL reset_rsp: got valid=%b data=%h flags=%b err=%b expected all 0",
                         rsp_valid, rsp_data, rsp_flags, rsp_err);
    end
    n_checks++;
    if ({alu_a, alu_b, alu_ctrl} !== 68'h0) begin
      n_fail++; $display("FAIL reset_alu: got a=%h b=%h ctrl=%h expected 0", alu_a, alu_b, alu_ctrl);
    end
    req_valid = 2'b00;
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_addu;
    tb_c = 1'b1; tb_v = 1'b1; tb_n = 1'b0;
    set_req(0, 4'b0010, 32'hFFFF_FFFF, 32'h1);
    req_valid = 2'b01;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL addu_grant: got %b expected 01", req_ready);
    end
    step;
    req_valid = 2'b00;
    n_checks++;
    if (rsp_valid !== 2'b00 || alu_ctrl !== 4'b0010 || alu_a !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL addu_exec: got rsp_valid=%b ctrl=%h a=%h expected 00/2/ffffffff",
                         rsp_valid, alu_ctrl, alu_a);
    end
    step;
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_flags} !== {2'b01, 32'h0, 4'b1101}) begin
      n_fail++; $display("FAIL addu_resp: got valid=%b data=%h flags=%b expected 01/0/1101",
                         rsp_valid, rsp_data, rsp_flags);
    end
    rsp_ready = 2'b01;
    step;
    rsp_ready = 2'b00;
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL addu_done: got rsp_valid=%b expected 00", rsp_valid);
    end
    tb_c = 1'b0; tb_v = 1'b0;
  endtask

  task automatic test_logic_flags;
    tb_c = 1'bx; tb_v = 1'bx; tb_n = 1'b0;
    set_req(1, 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0000);
    req_valid = 2'b10;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL logic_grant: got %b expected 10", req_ready);
    end
    step;
    req_valid = 2'b00;
    step;
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_flags} !== {2'b10, 32'h00F0_0000, 4'b0000}) begin
      n_fail++; $display("FAIL logic_resp: got valid=%b data=%h flags=%b expected 10/00f00000/0000",
                         rsp_valid, rsp_data, rsp_flags);
    end
    rsp_ready = 2'b10;
    step;
    rsp_ready = 2'b00;
    tb_c = 1'b0; tb_v = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g;
    logic [31:0] exp_d;
    logic saw_both;
    int w;
    saw_both = 1'b0;
    set_req(0, 4'b0010, 32'd1, 32'd2);
    set_req(1, 4'b0011, 32'd5, 32'd3);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      exp_d = (k % 2 == 1) ? 32'd6 : 32'd3;
      w = 0;
      while (req_ready == 2'b00 && w < 6) begin
        step; w++;
      end
      if (req_ready === 2'b11) saw_both = 1'b1;
      n_checks++;
      if (req_ready !== exp_g) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, exp_g);
      end
      step;
      if (req_ready === 2'b11) saw_both = 1'b1;
      step;
      n_checks++;
      if (rsp_valid !== exp_g || rsp_data !== exp_d) begin
        n_fail++; $display("FAIL rr_resp%0d: got valid=%b data=%h expected %b/%h",
                           k, rsp_valid, rsp_data, exp_g, exp_d);
      end
      step;
    end
    n_checks++;
    if (saw_both !== 1'b0) begin
      n_fail++; $display("FAIL rr_onehot: got req_ready=11 seen=%b expected 0", saw_both);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    step;
  endtask

  task automatic test_backpressure;
    set_req(0, 4'b0110, 32'd10, 32'd3);
    set_req(1, 4'b0001, 32'h3, 32'hC);
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL bp_grant0: got %b expected 01", req_ready);
    end
    step;
    req_valid = 2'b10;
    step;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({rsp_valid, req_ready, rsp_data, alu_ctrl, alu_a} !==
          {2'b01, 2'b00, 32'd7, 4'b0110, 32'd10}) begin
        n_fail++; $display("FAIL bp_hold%0d: got valid=%b ready=%b data=%h ctrl=%h a=%h expected 01/00/7/6/a",
                           i, rsp_valid, req_ready, rsp_data, alu_ctrl, alu_a);
      end
      step;
    end
    rsp_ready = 2'b01;
    step;
    n_checks++;
    if (req_ready !== 2'b10 || rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL bp_release: got ready=%b valid=%b expected 10/00", req_ready, rsp_valid);
    end
    step;
    req_valid = 2'b00;
    rsp_ready = 2'b10;
    step;
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== 32'hF) begin
      n_fail++; $display("FAIL bp_second: got valid=%b data=%h expected 10/f", rsp_valid, rsp_data);
    end
    step;
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid;
    set_req(0, 4'b0010, 32'd2, 32'd2);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    step;
    req_valid = 2'b00;
    step;
    step;
    rsp_ready = 2'b00;
    set_req(1, 4'b0010, 32'd7, 32'd1);
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL mid_pre_grant: got %b expected 10", req_ready);
    end
    step;
    req_valid = 2'b00;
    n_checks++;
    if (alu_a !== 32'd7) begin
      n_fail++; $display("FAIL mid_exec_a: got %h expected 7", alu_a);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_flags, rsp_err, alu_a, alu_b, alu_ctrl} !== 109'h0) begin
      n_fail++; $display("FAIL mid_async_clear: got valid=%b data=%h flags=%b err=%b a=%h b=%h ctrl=%h expected 0",
                         rsp_valid, rsp_data, rsp_flags, rsp_err, alu_a, alu_b, alu_ctrl);
    end
    step;
    rst_n = 1'b1;
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL mid_first_grant: got %b expected 01", req_ready);
    end
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step;
      n_checks++;
      if (rsp_valid !== 2'b00) begin
        n_fail++; $display("FAIL mid_no_resp%0d: got %b expected 00", i, rsp_valid);
      end
    end
  endtask

  task automatic test_opcheck;
    set_req(0, 4'b0001, 32'h30, 32'h03);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    step;
    req_valid = 2'b00;
    step;
    n_checks++;
    if (rsp_data !== 32'h33) begin
      n_fail++; $display("FAIL op_prior: got %h expected 33", rsp_data);
    end
    step;
    set_req(0, 4'b1000, 32'h1234, 32'h5);
    req_valid = 2'b01;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL op_grant: got %b expected 01", req_ready);
    end
    step;
    req_valid = 2'b00;
    step;
`ifdef ALU_ARB_OPCHECK_EN
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data, rsp_flags, alu_ctrl, alu_a} !==
        {2'b01, 1'b1, 32'h0, 4'b0000, 4'b0001, 32'h30}) begin
      n_fail++; $display("FAIL op_illegal: got valid=%b err=%b data=%h flags=%b ctrl=%h a=%h expected 01/1/0/0/1/30",
                         rsp_valid, rsp_err, rsp_data, rsp_flags, alu_ctrl, alu_a);
    end
`else
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data, alu_ctrl} !== {2'b01, 1'b0, 32'h1234, 4'b1000}) begin
      n_fail++; $display("FAIL op_forward: got valid=%b err=%b data=%h ctrl=%h expected 01/0/1234/8",
                         rsp_valid, rsp_err, rsp_data, alu_ctrl);
    end
`endif
    step;
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b10 || rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL op_rr_after: got ready=%b valid=%b expected 10/00", req_ready, rsp_valid);
    end
    req_valid = 2'b00;
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_addu;
    test_logic_flags;
    test_round_robin;
    test_backpressure;
    test_reset_mid;
    test_opcheck;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
